qarma64_arbiter: RTL and testbench

QARMA64_ARBITER -- requirements
Module: qarma64_arbiter

---
 rtl/qarma64_arbiter.sv | 175 +++++++++++++++++
 tb/tb_qarma64_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qarma64_arbiter.sv
// Two-requester round-robin front end for a single QARMA-64 core (IDLE/LOAD/RUN/RESP).
// Defining QARMA_ARB_TIMEOUT_EN adds a RUN-state abort timer limited by TIMEOUT_CYCLES.
module qarma64_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_in,
  input  logic [127:0] req_tweak,
  input  logic [255:0] req_key,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [63:0]  rsp_data,
  output logic         rsp_err,
  output logic         core_rst_n,
  output logic [63:0]  core_in,
  output logic [63:0]  core_tweak,
  output logic [127:0] core_key,
  input  logic [63:0]  core_out,
  input  logic         core_ready
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic          cur_id;
  logic          grant_any;
  logic          grant_id;
  logic [1:0]    grant_vec;
  logic [1:0]    cur_vec;
  logic [63:0]   hold_in;
  logic [63:0]   hold_tweak;
  logic [127:0]  hold_key;
  logic [63:0]   rsp_data_q;
  logic [1:0]    rsp_valid_q;
  logic          core_rst_n_q;
  logic          run_timeout;
  logic          run_abort;
  logic          rsp_taken;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
    grant_vec = grant_id ? 2'b10 : 2'b01;
  end

  assign cur_vec   = cur_id ? 2'b10 : 2'b01;
  assign rsp_taken = cur_id ? rsp_ready[1] : rsp_ready[0];
  assign run_abort = ~core_ready & run_timeout;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = LOAD;
          req_ready = grant_vec & {2{reset_n}};
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (core_ready || run_abort) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_taken) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      hold_in      <= '0;
      hold_tweak   <= '0;
      hold_key     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      // Registered so the load strobe is glitch-free and low while in reset.
      core_rst_n_q <= (state_nxt != LOAD);
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant_id;
            cur_id     <= grant_id;
            hold_in    <= grant_id ? req_in[127:64]    : req_in[63:0];
            hold_tweak <= grant_id ? req_tweak[127:64] : req_tweak[63:0];
            hold_key   <= grant_id ? req_key[255:128]  : req_key[127:0];
          end
        end
        RUN: begin
          if (core_ready) begin
            rsp_data_q  <= core_out;
            rsp_valid_q <= cur_vec;
          end else if (run_abort) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= cur_vec;
          end
        end
        RESP: begin
          if (rsp_taken) begin
            rsp_valid_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef QARMA_ARB_TIMEOUT_EN
  logic [5:0] timeout_cnt;
  logic       rsp_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeout_cnt <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state == LOAD) begin
        timeout_cnt <= '0;
      end else if (state == RUN) begin
        timeout_cnt <= timeout_cnt + 6'd1;
      end
      if (state == RUN && core_ready) begin
        rsp_err_q <= 1'b0;
      end else if (state == RUN && run_abort) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  // Abort is taken on the RUN cycle after the count reaches the limit,
  // giving 1 (accept) + 1 (LOAD) + TIMEOUT_CYCLES + 1 cycles to rsp_valid.
  assign run_timeout = ({1'b0, timeout_cnt} == 7'(TIMEOUT_CYCLES + 1));
  assign rsp_err     = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign run_timeout        = 1'b0;
  assign rsp_err            = 1'b0;
`endif

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign core_rst_n = core_rst_n_q;
  assign core_in    = hold_in;
  assign core_tweak = hold_tweak;
  assign core_key   = hold_key;

endmodule

// File: tb/tb_qarma64_arbiter.sv
// Self-checking bench for qarma64_arbiter with a stand-in core of programmable latency.
// Timeout scenario is compiled only when QARMA_ARB_TIMEOUT_EN is defined.
module tb_qarma64_arbiter;
  localparam int unsigned TO = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_in = '0;
  logic [127:0] req_tweak = '0;
  logic [255:0] req_key = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = '0;
  logic [63:0]  rsp_data;
  logic         rsp_err;
  logic         core_rst_n;
  logic [63:0]  core_in, core_tweak, core_out;
  logic [127:0] core_key;
  logic         core_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int core_lat = 18;
  bit core_hang = 1'b0;
  int core_cnt = 0;
  logic [63:0] core_res = '0;
  bit ref_last = 1'b1;

  qarma64_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in(req_in), .req_tweak(req_tweak), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_rst_n(core_rst_n), .core_in(core_in), .core_tweak(core_tweak),
    .core_key(core_key), .core_out(core_out), .core_ready(core_ready)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: any fixed mixing of all three inputs exposes routing errors.
  function automatic logic [63:0] core_fn(input logic [63:0] p, input logic [63:0] t,
                                          input logic [127:0] k);
    return p ^ {t[31:0], t[63:32]} ^ k[63:0] ^ (k[127:64] + 64'd1);
  endfunction

  // Round-robin rule: tie goes to the requester that did not win last.
  function automatic int pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_cnt   <= 0;
      core_ready <= 1'b0;
      core_res   <= core_fn(core_in, core_tweak, core_key);
    end else if (!core_hang && !core_ready) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_lat) core_ready <= 1'b1;
    end
  end
  assign core_out = core_ready ? core_res : 64'h0bad_0bad_0bad_0bad;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [63:0] p, input logic [63:0] t,
                         input logic [127:0] k);
    req_in[64*idx +: 64]    = p;
    req_tweak[64*idx +: 64] = t;
    req_key[128*idx +: 128] = k;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
    ref_last = 1'b1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == 2'b00 && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00)
      $display("FAIL reset_handshake: ready=%b valid=%b expected 00 00", req_ready, rsp_valid);
    checks++;
    if (rsp_data !== 64'h0 || rsp_err !== 1'b0)
      $display("FAIL reset_rsp: data=%h err=%b expected 0 0", rsp_data, rsp_err);
    checks++;
    if (core_rst_n !== 1'b0)
      $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n);
    checks++;
    if ({core_in, core_tweak, core_key} !== 256'h0)
      $display("FAIL reset_hold: in=%h tw=%h key=%h expected 0", core_in, core_tweak, core_key);
    failures += ((req_ready !== 2'b00 || rsp_valid !== 2'b00) ? 1 : 0)
              + ((rsp_data !== 64'h0 || rsp_err !== 1'b0) ? 1 : 0)
              + ((core_rst_n !== 1'b0) ? 1 : 0)
              + (({core_in, core_tweak, core_key} !== 256'h0) ? 1 : 0);
  endtask

  task automatic test_single();
    logic [63:0] p = 64'hfb623599da6e8127;
    logic [63:0] t = 64'h477d469dec0b8762;
    logic [127:0] k = {64'h84be85ce9804e94b, 64'hec2802d4e0a488e9};
    int n;
    core_lat = 18;
    set_req(0, p, t, k);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    ref_last = 1'b0;
    #1;
    checks++;
    if ({core_in, core_tweak, core_key, core_rst_n} !== {p, t, k, 1'b0}) begin
      failures++;
      $display("FAIL single_load: in=%h tw=%h key=%h rst_n=%b", core_in, core_tweak, core_key, core_rst_n);
    end
    wait_rsp(n);
    checks++;
    if (n !== 20) begin
      failures++; $display("FAIL single_latency: got %0d expected 20", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, core_fn(p, t, k)}) begin
      failures++;
      $display("FAIL single_rsp: valid=%b err=%b data=%h expected 01 0 %h", rsp_valid, rsp_err, rsp_data, core_fn(p, t, k));
    end
    checks++;
    if ({core_in, core_tweak, core_key} !== {p, t, k}) begin
      failures++; $display("FAIL single_hold_stable: in=%h expected %h", core_in, p);
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL single_release: valid=%b expected 00", rsp_valid);
    end
  endtask

  task automatic test_tie();
    logic [63:0] p[2], t[2];
    logic [127:0] k[2];
    int n;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      p[r] = {$urandom, $urandom}; t[r] = {$urandom, $urandom};
      k[r] = {$urandom, $urandom, $urandom, $urandom};
      set_req(r, p[r], t[r], k[r]);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== (pick(2'b11, ref_last) == 0 ? 2'b01 : 2'b10)) begin
      failures++; $display("FAIL tie_first_grant: got %b expected 01", req_ready);
    end
    cyc();
    ref_last = 1'b0;
    req_valid = 2'b10;
    wait_rsp(n);
    checks++;
    if ({n, rsp_valid, rsp_data} !== {32'd20, 2'b01, core_fn(p[0], t[0], k[0])}) begin
      failures++; $display("FAIL tie_rsp0: n=%0d valid=%b data=%h", n, rsp_valid, rsp_data);
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL tie_second_grant: got %b expected 10", req_ready);
    end
    cyc();
    ref_last = 1'b1;
    req_valid = 2'b00;
    wait_rsp(n);
    checks++;
    if ({n, rsp_valid, rsp_data} !== {32'd20, 2'b10, core_fn(p[1], t[1], k[1])}) begin
      failures++; $display("FAIL tie_rsp1: n=%0d valid=%b data=%h", n, rsp_valid, rsp_data);
    end
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
  endtask

  task automatic test_hold();
    logic [63:0] p = {$urandom, $urandom};
    logic [63:0] t = {$urandom, $urandom};
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    logic [63:0] exp_d = core_fn(p, t, k);
    int n;
    set_req(1, p, t, k);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL hold_grant: got %b expected 10", req_ready);
    end
    cyc();
    ref_last = 1'b1;
    req_valid = 2'b00;
    wait_rsp(n);
    for (int c = 0; c < 10; c++) begin
      req_valid = 2'b11;
      rsp_ready = 2'b01;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_data} !== {2'b00, 2'b10, 1'b0, exp_d}) begin
        failures++;
        $display("FAIL hold_stable: cycle %0d ready=%b valid=%b data=%h expected 00 10 %h", c, req_ready, rsp_valid, rsp_data, exp_d);
      end
      cyc();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL hold_release: valid=%b expected 00", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] p = {$urandom, $urandom};
    logic [63:0] t = {$urandom, $urandom};
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    bit silent = 1'b1;
    int n;
    core_lat = 18;
    set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, {4{$urandom}});
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    repeat (5) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    ref_last = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_data, core_rst_n, core_in, core_key} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: ready=%b valid=%b err=%b data=%h rst_n=%b in=%h", req_ready, rsp_valid, rsp_err, rsp_data, core_rst_n, core_in);
    end
    repeat (30) begin
      cyc();
      if (rsp_valid !== 2'b00) silent = 1'b0;
    end
    checks++;
    if (!silent) begin
      failures++; $display("FAIL midreset_dropped: got a response expected none");
    end
    set_req(1, p, t, k);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL midreset_regrant: got %b expected 10", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    wait_rsp(n);
    checks++;
    if ({n, rsp_valid, rsp_err, rsp_data} !== {32'd20, 2'b10, 1'b0, core_fn(p, t, k)}) begin
      failures++; $display("FAIL midreset_rsp: n=%0d valid=%b data=%h", n, rsp_valid, rsp_data);
    end
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [63:0] p[2], t[2];
    logic [127:0] k[2];
    int n;
    core_lat = 18;
    for (int i = 0; i < 2; i++) begin
      p[i] = {$urandom, $urandom}; t[i] = {$urandom, $urandom};
      k[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    set_req(0, p[0], t[0], k[0]);
    req_valid = 2'b01;
    cyc();
    ref_last = 1'b0;
    wait_rsp(n);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    set_req(0, p[1], t[1], k[1]);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL b2b_accept: got %b expected 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    wait_rsp(n);
    checks++;
    if ({n, rsp_valid, rsp_data} !== {32'd20, 2'b01, core_fn(p[1], t[1], k[1])}) begin
      failures++; $display("FAIL b2b_rsp: n=%0d valid=%b data=%h", n, rsp_valid, rsp_data);
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [63:0] p[2], t[2];
    logic [127:0] k[2];
    logic [1:0] pat, exp_v;
    logic [63:0] exp_d;
    int win, n, lat, dly;
    bit early;
    for (int x = 0; x < 40; x++) begin
      pat = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        p[r] = {$urandom, $urandom}; t[r] = {$urandom, $urandom};
        k[r] = {$urandom, $urandom, $urandom, $urandom};
        set_req(r, p[r], t[r], k[r]);
      end
      lat = $urandom_range(1, 30);
      core_lat = lat;
      win = pick(pat, ref_last);
      exp_v = (win == 0) ? 2'b01 : 2'b10;
      exp_d = core_fn(p[win], t[win], k[win]);
      req_valid = pat;
      #1;
      checks++;
      if (req_ready !== exp_v) begin
        failures++; $display("FAIL rand_grant: txn %0d pat=%b got %b expected %b", x, pat, req_ready, exp_v);
      end
      cyc();
      ref_last = (win == 1);
      early = 1'b0;
      n = 0;
      while (rsp_valid == 2'b00 && n < 200) begin
        if (req_ready !== 2'b00) early = 1'b1;
        cyc();
        n++;
      end
      checks++;
      if (n != lat + 2 || early) begin
        failures++; $display("FAIL rand_latency: txn %0d got %0d expected %0d busy_ready=%0d", x, n, lat + 2, early);
      end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        rsp_ready = 2'($urandom) & ~exp_v;
        cyc();
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {exp_v, 1'b0, exp_d}) begin
        failures++;
        $display("FAIL rand_rsp: txn %0d valid=%b err=%b data=%h expected %b 0 %h", x, rsp_valid, rsp_err, rsp_data, exp_v, exp_d);
      end
      rsp_ready = exp_v;
      cyc();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    core_lat = 18;
  endtask

`ifdef QARMA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    core_hang = 1'b1;
    set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, {4{$urandom}});
    req_valid = 2'b01;
    cyc();
    ref_last = 1'b0;
    req_valid = 2'b00;
    wait_rsp(n);
    checks++;
    if (n != int'(TO) + 3) begin
      failures++; $display("FAIL timeout_latency: got %0d expected %0d", n, TO + 3);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b1, 64'h0}) begin
      failures++; $display("FAIL timeout_rsp: valid=%b err=%b data=%h expected 01 1 0", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;
    core_hang = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef QARMA_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
